// File: rtl/button_arb_pkg.sv
// rtl/button_arb_pkg.sv - shared types and helpers for button_event_arbiter
package button_arb_pkg;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

    // Index width for a given button count, never narrower than one bit.
    function automatic int calc_id_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/button_event_arbiter_rr_picker.sv
// rtl/button_event_arbiter_rr_picker.sv - combinational round-robin picker (module rr_picker)
module rr_picker
    import button_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ID_W  = calc_id_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_idx
);

    int idx;

    // Search begins just after the last winner, so the last winner ranks lowest.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 1; k <= WIDTH; k++) begin
            idx = (int'(rr_ptr) + k) % WIDTH;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - serializes button pulses onto one valid/ready channel; BUTTON_ARB_DROP_CNT_EN adds drop_cnt
module button_event_arbiter
    import button_arb_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int ID_W       = calc_id_w(WIDTH),
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      btn_pulse,
    output logic                  evt_valid,
    output logic [ID_W-1:0]       evt_id,
    input  logic                  evt_ready,
    output logic [WIDTH-1:0]      pending
`ifdef BUTTON_ARB_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam logic [ID_W-1:0] PTR_RST = ID_W'(WIDTH - 1);

    if (WIDTH < 2 || DROP_CNT_W < 1) begin : g_bad_param
        $error("button_event_arbiter: WIDTH must be >= 2 and DROP_CNT_W >= 1");
    end

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  evt_id_q, evt_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] grant_mask;
    logic [WIDTH-1:0] drop_mask;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_idx;
    logic             load;

    assign req = pending_q | btn_pulse;

    rr_picker #(
        .WIDTH (WIDTH),
        .ID_W  (ID_W)
    ) u_rr_picker (
        .req         (req),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d  = state_q;
        evt_id_d = evt_id_q;
        rr_ptr_d = rr_ptr_q;
        load     = ((state_q == ARB_EMPTY) || evt_ready) && grant_valid;

        for (int i = 0; i < WIDTH; i++) begin
            grant_mask[i] = load && (grant_idx == ID_W'(i));
        end

        // A granted slot only stays pending if a fresh pulse re-arms it.
        pending_d = (req & ~grant_mask) | (grant_mask & pending_q & btn_pulse);
        drop_mask = pending_q & btn_pulse & ~grant_mask;

        case (state_q)
            ARB_EMPTY: begin
                if (load) begin
                    state_d = ARB_FULL;
                end
            end
            ARB_FULL: begin
                if (evt_ready && !load) begin
                    state_d = ARB_EMPTY;
                end
            end
            default: state_d = ARB_EMPTY;
        endcase

        if (load) begin
            evt_id_d = grant_idx;
            rr_ptr_d = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_EMPTY;
            evt_id_q  <= '0;
            rr_ptr_q  <= PTR_RST;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            evt_id_q  <= evt_id_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
        end
    end

    assign evt_valid = (state_q == ARB_FULL);
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;

`ifdef BUTTON_ARB_DROP_CNT_EN
    localparam int unsigned CNT_MAX = (2 ** DROP_CNT_W) - 1;

    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    int unsigned           n_drops;
    int unsigned           cnt_sum;

    always_comb begin
        n_drops = 0;
        for (int i = 0; i < WIDTH; i++) begin
            n_drops = n_drops + {31'd0, drop_mask[i]};
        end
        cnt_sum    = {{(32 - DROP_CNT_W){1'b0}}, drop_cnt_q} + n_drops;
        drop_cnt_d = (cnt_sum > CNT_MAX) ? DROP_CNT_W'(CNT_MAX) : DROP_CNT_W'(cnt_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = |drop_mask;
`endif

endmodule
